// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit timing and transmitter FSM states.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO with occupancy count; all updates are qualified by clkEn.
// A write that coincides with a pop is accepted even when full, so the slot is reused in place.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rstB,
   input  logic                     clkEn,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     ready,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_full;
   logic          w_push;
   logic          w_pop;

   assign w_full = (r_count == (AW+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_pop  = clkEn & pop & ~empty;
   assign ready  = ~w_full | w_pop;
   assign w_push = clkEn & push & ready;
   assign head   = r_mem[r_rd_ptr];
   assign count  = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH (a power of two).
   always_ff @(posedge clk or negedge rstB) begin
      if (!rstB) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter (start, 8 data bits LSB first, stop). Defining
// UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rstB,
   input  logic                          clkEn,
   input  logic                          wr_en,
   input  logic [UART_DATA_W-1:0]        wr_data,
   output logic                          wr_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   uart_state_e            r_state;
   logic [CW-1:0]          r_bit_cnt;
   logic [2:0]             r_bit_idx;
   logic [UART_DATA_W-1:0] r_data;
   logic                   r_tx;
   logic                   w_bit_end;
   logic                   w_pop_req;
   logic                   w_empty;
   logic [UART_DATA_W-1:0] w_head;

   assign w_bit_end = (r_bit_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_pop_req = !w_empty && (r_state == ST_IDLE || (r_state == ST_STOP && w_bit_end));
   assign tx        = r_tx;
   assign busy      = (r_state != ST_IDLE) || !w_empty;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (UART_DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rstB      (rstB),
      .clkEn     (clkEn),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (w_pop_req),
      .head      (w_head),
      .ready     (wr_ready),
      .empty     (w_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rstB) begin
      if (!rstB) begin
         r_bit_cnt <= '0;
      end else if (clkEn) begin
         if (r_state == ST_IDLE || w_bit_end) r_bit_cnt <= '0;
         else                                 r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   // tx is registered from the current state, so each bit appears one edge after its state begins.
   always_ff @(posedge clk or negedge rstB) begin
      if (!rstB) begin
         r_state   <= ST_IDLE;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_tx      <= 1'b1;
      end else if (clkEn) begin
         case (r_state)
            ST_IDLE: begin
               r_tx <= 1'b1;
               if (!w_empty) begin
                  r_data  <= w_head;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_tx <= 1'b0;
               if (w_bit_end) begin
                  r_bit_idx <= '0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               r_tx <= r_data[r_bit_idx];
               if (w_bit_end) begin
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               r_tx <= even_parity(r_data);
               if (w_bit_end) r_state <= ST_STOP;
            end
`endif
            ST_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  if (!w_empty) begin
                     r_data  <= w_head;
                     r_state <= ST_START;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line waveform compared against frames built from the
// byte values; honours UART_TX_PARITY_EN for the 11-bit frame.
module tb_uart_tx;

   localparam int C     = 20;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int F = NB * C;

   logic       clk     = 1'b0;
   logic       rstB    = 1'b0;
   logic       clkEn   = 1'b1;
   logic       wr_en   = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int checks   = 0;
   int failures = 0;

   uart_tx #(
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rstB       (rstB),
      .clkEn      (clkEn),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Frame position i: 0 start, 1..8 data LSB first, optional even parity, then stop.
   function automatic logic exp_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (NB == 11 && i == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      wr_data = b;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_start(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL start_timeout tx=%0b after %0d cycles, required start bit 0", tx, limit);
      end
   endtask

   // Called on the negedge holding the first start-bit sample; consumes exactly F enabled samples.
   task automatic check_frame(input logic [7:0] b, input int stall_at, input int stall_len);
      int   bad;
      int   stall_bad;
      logic e;
      stall_bad = 0;
      for (int bi = 0; bi < NB; bi++) begin
         e   = exp_bit(b, bi);
         bad = 0;
         for (int s = 0; s < C; s++) begin
            if (bi > 0 || s > 0) @(negedge clk);
            if (tx !== e) bad++;
            if (bi * C + s == stall_at) begin
               clkEn = 1'b0;
               repeat (stall_len) begin
                  @(negedge clk);
                  if (tx !== e) stall_bad++;
               end
               clkEn = 1'b1;
            end
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL frame_bit byte=%02h bit=%0d wrong_samples=%0d of %0d, required tx=%0b",
                     b, bi, bad, C, e);
         end
      end
      if (stall_at >= 0) begin
         checks++;
         if (stall_bad != 0) begin
            failures++;
            $display("FAIL clken_hold byte=%02h tx changed in %0d of %0d stalled cycles, required 0",
                     b, stall_bad, stall_len);
         end
      end
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if (busy !== 1'b0 || fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL %s busy=%0b fifo_count=%0d, required busy=0 fifo_count=0", tag, busy, fifo_count);
      end
   endtask

   task automatic check_latency(input string tag);
      int lat;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (tx === 1'b0) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL %s write-to-start latency=%0d, required 2", tag, lat);
      end
   endtask

   task automatic test_reset();
      int bad;
      rstB  = 1'b0;
      wr_en = 1'b0;
      clkEn = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx tx=%0b, required 1", tx); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%0b, required 0", busy); end
      checks++;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready wr_ready=%0b, required 1", wr_ready); end
      checks++;
      if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count fifo_count=%0d, required 0", fifo_count); end
      rstB = 1'b1;
      bad  = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL post_reset_idle active cycles=%0d, required 0", bad); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      write_byte(8'h51);
      check_latency("single_0x51");
      check_frame(8'h51, -1, 0);
      check_idle("single_0x51_end");
      $display("test_single byte=51 frame_cycles=%0d", F);
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         sa;
      int         sl;
      bit         ok;
      for (int n = 0; n < 4; n++) begin
         b  = 8'($urandom);
         sa = $urandom_range(F - C - 1, C);
         sl = $urandom_range(40, 1);
         write_byte(b);
         wait_start(10, ok);
         if (ok) check_frame(b, sa, sl);
         check_idle("random_end");
         $display("test_random byte=%02h stall_at=%0d stall_len=%0d", b, sa, sl);
      end
   endtask

   task automatic test_clken();
      logic [7:0] b;
      bit         ok;
      int         bad;
      b = 8'($urandom);
      write_byte(b);
      wait_start(10, ok);
      if (ok) check_frame(b, 3 * C + C / 2, 1000);
      check_idle("clken_stall_end");
      $display("test_clken stall byte=%02h len=1000", b);
      @(negedge clk);
      clkEn   = 1'b0;
      wr_en   = 1'b1;
      wr_data = 8'h3C;
      repeat (10) @(negedge clk);
      wr_en = 1'b0;
      check_idle("clken_low_write");
      clkEn = 1'b1;
      bad   = 0;
      repeat (2 * C) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL clken_low_write_frame tx low cycles=%0d, required 0", bad); end
      $display("test_clken ignored writes while disabled");
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[5];
      logic [7:0] exp_q[$];
      int         expc[5];
      expc = '{1, 1, 2, 3, 4};
      for (int i = 0; i < 5; i++) begin
         b[i] = 8'($urandom);
         exp_q.push_back(b[i]);
      end
      exp_q.push_back(8'hC3);
      fork
         begin
            int hold_bad;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (i > 0) begin
                  checks++;
                  if (fifo_count !== 3'(expc[i-1])) begin
                     failures++;
                     $display("FAIL b2b_count after write %0d fifo_count=%0d, required %0d", i - 1, fifo_count, expc[i-1]);
                  end
               end
               wr_data = b[i];
               wr_en   = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (fifo_count !== 3'd4) begin failures++; $display("FAIL b2b_full_count fifo_count=%0d, required 4", fifo_count); end
            checks++;
            if (wr_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready wr_ready=%0b, required 0", wr_ready); end
            wr_data  = 8'hC3;
            hold_bad = 0;
            repeat (F + 10) begin
               @(negedge clk);
               if (fifo_count !== 3'd4) hold_bad++;
            end
            wr_en = 1'b0;
            checks++;
            if (hold_bad != 0) begin
               failures++;
               $display("FAIL full_pop_count fifo_count left 4 in %0d cycles, required 0", hold_bad);
            end
         end
         begin
            bit ok;
            int bad;
            wait_start(20, ok);
            if (ok) begin
               for (int j = 0; j < 6; j++) begin
                  if (j > 0) @(negedge clk);
                  check_frame(exp_q[j], -1, 0);
                  $display("test_back_to_back frame=%0d byte=%02h", j, exp_q[j]);
               end
               check_idle("b2b_end");
               bad = 0;
               repeat (3 * C) begin
                  @(negedge clk);
                  if (tx !== 1'b1) bad++;
               end
               checks++;
               if (bad != 0) begin failures++; $display("FAIL b2b_extra_frame tx low cycles=%0d, required 0", bad); end
            end
         end
      join
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      bit         ok;
      int         bad;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wr_data = 8'h00;
         wr_en   = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
      wait_start(10, ok);
      repeat (F / 2 - 1) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin failures++; $display("FAIL midframe_pre tx=%0b, required 0", tx); end
      rstB = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL async_reset_tx tx=%0b, required 1", tx); end
      checks++;
      if (fifo_count !== 3'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_state fifo_count=%0d busy=%0b wr_ready=%0b, required 0 0 1",
                  fifo_count, busy, wr_ready);
      end
      repeat (5) @(negedge clk);
      rstB = 1'b1;
      bad  = 0;
      repeat (3 * F) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL reset_discard active cycles=%0d, required 0", bad); end
      b = 8'($urandom);
      write_byte(b);
      check_latency("after_reset");
      check_frame(b, -1, 0);
      check_idle("after_reset_end");
      $display("test_reset_midframe new byte=%02h", b);
   endtask

   initial begin
      test_reset();
      test_single();
      test_random();
      test_clken();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
